// File: rtl/byp_hazard_ctrl.sv
// ID-stage forwarding and load-use hazard controller.
// Tracks {dst,we,ld} of the instructions in EX (ID_EX) and DM (EX_DM). It
// registers the per-port bypass selects into the ID_EX boundary, raises a
// one-cycle load-use stall, and injects a bubble into ID_EX when it stalls.
module byp_hazard_ctrl #(
  parameter int RADDR_W  = 4,
  parameter int ZERO_BYP = 0,
  parameter int CNT_W    = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_stall_ID_EX,
  input  logic               i_stall_EX_DM,
  input  logic               i_flush,
  input  logic [RADDR_W-1:0] i_p0_addr,
  input  logic [RADDR_W-1:0] i_p1_addr,
  input  logic               i_re0,
  input  logic               i_re1,
  input  logic [RADDR_W-1:0] i_dst_addr_ID,
  input  logic               i_we_ID,
  input  logic               i_ld_ID,
  output logic               o_byp0_EX,
  output logic               o_byp0_DM,
  output logic               o_byp1_EX,
  output logic               o_byp1_DM,
  output logic               o_ldu_stall,
  output logic [CNT_W-1:0]   o_ldu_cnt,
  output logic               o_stall_err
);

  // A producer matches a read address only if it writes the RF; R0 is
  // excluded unless it is configured as an ordinary register.
  function automatic logic f_hit(input logic [RADDR_W-1:0] a,
                                 input logic [RADDR_W-1:0] dst,
                                 input logic               we);
    return we && (dst == a) && ((ZERO_BYP != 0) || (a != '0));
  endfunction

  logic [RADDR_W-1:0] r_idex_dst;
  logic               r_idex_we;
  logic               r_idex_ld;
  logic [RADDR_W-1:0] r_exdm_dst;
  logic               r_exdm_we;
  logic               r_exdm_ld;
  logic               r_byp0_ex;
  logic               r_byp0_dm;
  logic               r_byp1_ex;
  logic               r_byp1_dm;
  logic [CNT_W-1:0]   r_ldu_cnt;
  logic               r_stall_err;

  logic w_hit0_ex;
  logic w_hit0_dm;
  logic w_hit1_ex;
  logic w_hit1_dm;
  logic w_ldu_stall;
  logic w_kill;

  // Address compares of the ID read ports against the EX and DM producers.
  always_comb begin
    w_hit0_ex   = i_re0 && f_hit(i_p0_addr, r_idex_dst, r_idex_we);
    w_hit0_dm   = i_re0 && f_hit(i_p0_addr, r_exdm_dst, r_exdm_we);
    w_hit1_ex   = i_re1 && f_hit(i_p1_addr, r_idex_dst, r_idex_we);
    w_hit1_dm   = i_re1 && f_hit(i_p1_addr, r_exdm_dst, r_exdm_we);
    // A load in EX cannot forward yet; a flushed consumer needs no stall.
    w_ldu_stall = r_idex_ld && (w_hit0_ex || w_hit1_ex) && !i_flush;
    w_kill      = i_flush || w_ldu_stall;
  end

  // ID_EX tracking and registered bypass selects; bubble on flush or load-use.
  // EX and DM selects may both be set: the source mux gives EX priority.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idex_dst <= '0;
      r_idex_we  <= 1'b0;
      r_idex_ld  <= 1'b0;
      r_byp0_ex  <= 1'b0;
      r_byp0_dm  <= 1'b0;
      r_byp1_ex  <= 1'b0;
      r_byp1_dm  <= 1'b0;
    end else if (!i_stall_ID_EX) begin
      if (w_kill) begin
        r_idex_dst <= '0;
        r_idex_we  <= 1'b0;
        r_idex_ld  <= 1'b0;
        r_byp0_ex  <= 1'b0;
        r_byp0_dm  <= 1'b0;
        r_byp1_ex  <= 1'b0;
        r_byp1_dm  <= 1'b0;
      end else begin
        r_idex_dst <= i_dst_addr_ID;
        r_idex_we  <= i_we_ID;
        r_idex_ld  <= i_ld_ID;
        r_byp0_ex  <= w_hit0_ex;
        r_byp0_dm  <= w_hit0_dm;
        r_byp1_ex  <= w_hit1_ex;
        r_byp1_dm  <= w_hit1_dm;
      end
    end
  end

  // EX_DM tracking: shift from ID_EX, or take a bubble when ID_EX is held
  // alone so the held instruction is not duplicated downstream.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_exdm_dst <= '0;
      r_exdm_we  <= 1'b0;
      r_exdm_ld  <= 1'b0;
    end else if (!i_stall_EX_DM) begin
      if (i_stall_ID_EX) begin
        r_exdm_dst <= '0;
        r_exdm_we  <= 1'b0;
        r_exdm_ld  <= 1'b0;
      end else begin
        r_exdm_dst <= r_idex_dst;
        r_exdm_we  <= r_idex_we;
        r_exdm_ld  <= r_idex_ld;
      end
    end
  end

  // Saturating count of load-use stall cycles that actually took effect.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ldu_cnt <= '0;
    end else if (w_ldu_stall && !i_stall_ID_EX && (r_ldu_cnt != {CNT_W{1'b1}})) begin
      r_ldu_cnt <= r_ldu_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Sticky flag for a mismatched stall pair (only 00 and 11 are legal).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_err <= 1'b0;
    end else if (i_stall_ID_EX != i_stall_EX_DM) begin
      r_stall_err <= 1'b1;
    end
  end

  assign o_byp0_EX   = r_byp0_ex;
  assign o_byp0_DM   = r_byp0_dm;
  assign o_byp1_EX   = r_byp1_ex;
  assign o_byp1_DM   = r_byp1_dm;
  assign o_ldu_stall = w_ldu_stall;
  assign o_ldu_cnt   = r_ldu_cnt;
  assign o_stall_err = r_stall_err;

endmodule

// File: tb/tb_byp_hazard_ctrl.sv
// Directed bench for byp_hazard_ctrl: a per-cycle vector table on the
// default configuration, then hand sequences for R0 handling, async reset,
// and counter saturation (on a narrow-counter instance with ZERO_BYP=1).
module tb_byp_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       sie, sed, fl;
  logic [3:0] p0, p1, dst;
  logic       re0, re1, we, ld;

  logic        b0e0, b0d0, b1e0, b1d0, ldu0, err0;
  logic [15:0] cnt0;
  logic        b0e1, b0d1, b1e1, b1d1, ldu1, err1;
  logic [3:0]  cnt1;

  int n_vec = 0;
  int n_err = 0;

  byp_hazard_ctrl #(.RADDR_W(4), .ZERO_BYP(0), .CNT_W(16)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall_ID_EX(sie), .i_stall_EX_DM(sed),
    .i_flush(fl), .i_p0_addr(p0), .i_p1_addr(p1), .i_re0(re0), .i_re1(re1),
    .i_dst_addr_ID(dst), .i_we_ID(we), .i_ld_ID(ld),
    .o_byp0_EX(b0e0), .o_byp0_DM(b0d0), .o_byp1_EX(b1e0), .o_byp1_DM(b1d0),
    .o_ldu_stall(ldu0), .o_ldu_cnt(cnt0), .o_stall_err(err0));

  byp_hazard_ctrl #(.RADDR_W(4), .ZERO_BYP(1), .CNT_W(4)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall_ID_EX(sie), .i_stall_EX_DM(sed),
    .i_flush(fl), .i_p0_addr(p0), .i_p1_addr(p1), .i_re0(re0), .i_re1(re1),
    .i_dst_addr_ID(dst), .i_we_ID(we), .i_ld_ID(ld),
    .o_byp0_EX(b0e1), .o_byp0_DM(b0d1), .o_byp1_EX(b1e1), .o_byp1_DM(b1d1),
    .o_ldu_stall(ldu1), .o_ldu_cnt(cnt1), .o_stall_err(err1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sie, sed, fl;
    logic        re0; logic [3:0] p0;
    logic        re1; logic [3:0] p1;
    logic        we, ld; logic [3:0] dst;
    logic        e_ldu;
    logic [3:0]  e_byp;   // {byp0_EX, byp0_DM, byp1_EX, byp1_DM} after the edge
    logic [15:0] e_cnt;
    logic        e_err;
  } vec_t;

  vec_t vt[23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic re0_i, input logic [3:0] p0_i,
                       input logic re1_i, input logic [3:0] p1_i,
                       input logic we_i, input logic ld_i, input logic [3:0] dst_i);
    re0 = re0_i; p0 = p0_i; re1 = re1_i; p1 = p1_i;
    we = we_i; ld = ld_i; dst = dst_i;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // sie sed fl  re0 p0  re1 p1  we ld dst  ldu  byp      cnt err
    vt[0]  = '{0,0,0, 0,0,  0,0,  1,0,3,  0, 4'b0000, 0, 0};
    vt[1]  = '{0,0,0, 1,3,  1,7,  1,0,6,  0, 4'b1000, 0, 0};
    vt[2]  = '{0,0,0, 1,1,  0,0,  1,0,4,  0, 4'b0000, 0, 0};
    vt[3]  = '{0,0,0, 0,0,  0,0,  1,0,8,  0, 4'b0000, 0, 0};
    vt[4]  = '{0,0,0, 1,9,  1,4,  0,0,9,  0, 4'b0001, 0, 0};
    vt[5]  = '{0,0,0, 0,0,  0,0,  1,0,5,  0, 4'b0000, 0, 0};
    vt[6]  = '{0,0,0, 0,0,  0,0,  1,0,5,  0, 4'b0000, 0, 0};
    vt[7]  = '{0,0,0, 1,5,  1,5,  0,0,0,  0, 4'b1111, 0, 0};
    vt[8]  = '{0,0,0, 0,0,  0,0,  1,1,2,  0, 4'b0000, 0, 0};
    vt[9]  = '{0,0,0, 1,2,  1,3,  1,0,7,  1, 4'b0000, 1, 0};
    vt[10] = '{0,0,0, 1,2,  1,3,  1,0,7,  0, 4'b0100, 1, 0};
    vt[11] = '{0,0,0, 0,0,  0,0,  1,0,0,  0, 4'b0000, 1, 0};
    vt[12] = '{0,0,0, 1,0,  0,0,  1,0,1,  0, 4'b0000, 1, 0};
    vt[13] = '{0,0,0, 0,0,  0,0,  1,1,6,  0, 4'b0000, 1, 0};
    vt[14] = '{0,0,1, 1,6,  0,0,  1,0,10, 0, 4'b0000, 1, 0};
    vt[15] = '{0,0,0, 0,0,  1,6,  0,0,0,  0, 4'b0001, 1, 0};
    vt[16] = '{1,1,0, 1,6,  0,0,  0,0,0,  0, 4'b0001, 1, 0};
    vt[17] = '{0,0,0, 0,0,  0,0,  1,1,11, 0, 4'b0000, 1, 0};
    vt[18] = '{1,1,0, 1,11, 0,0,  1,0,12, 1, 4'b0000, 1, 0};
    vt[19] = '{0,0,0, 1,11, 0,0,  1,0,12, 1, 4'b0000, 2, 0};
    vt[20] = '{0,0,0, 1,11, 0,0,  1,0,12, 0, 4'b0100, 2, 0};
    vt[21] = '{1,0,0, 0,0,  0,0,  0,0,0,  0, 4'b0100, 2, 1};
    vt[22] = '{0,0,0, 1,12, 0,0,  0,0,0,  0, 4'b1000, 2, 1};

    rst_n = 1'b0; sie = 0; sed = 0; fl = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset byp", {28'd0, b0e0, b0d0, b1e0, b1d0}, 0);
    chk("reset ldu_stall", {31'd0, ldu0}, 0);
    chk("reset ldu_cnt", {16'd0, cnt0}, 0);
    chk("reset stall_err", {31'd0, err0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 23; i++) begin
      sie = vt[i].sie; sed = vt[i].sed; fl = vt[i].fl;
      drive(vt[i].re0, vt[i].p0, vt[i].re1, vt[i].p1, vt[i].we, vt[i].ld, vt[i].dst);
      #1;
      chk($sformatf("vec%0d ldu_stall", i), {31'd0, ldu0}, {31'd0, vt[i].e_ldu});
      step();
      chk($sformatf("vec%0d byp", i), {28'd0, b0e0, b0d0, b1e0, b1d0}, {28'd0, vt[i].e_byp});
      chk($sformatf("vec%0d ldu_cnt", i), {16'd0, cnt0}, {16'd0, vt[i].e_cnt});
      chk($sformatf("vec%0d stall_err", i), {31'd0, err0}, {31'd0, vt[i].e_err});
    end

    // stall_err stays set while stalls are legal again
    sie = 0; sed = 0; fl = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("stall_err sticky", {31'd0, err0}, 1);

    // R0 handling: ZERO_BYP=0 ignores R0, ZERO_BYP=1 forwards and stalls on it
    rst_n = 1'b0; #2; rst_n = 1'b1;
    step();
    drive(0, 0, 0, 0, 1, 0, 0);
    step();
    drive(1, 0, 0, 0, 1, 0, 1);
    #1;
    chk("r0 alu ldu zb0", {31'd0, ldu0}, 0);
    chk("r0 alu ldu zb1", {31'd0, ldu1}, 0);
    step();
    chk("r0 byp zb0", {28'd0, b0e0, b0d0, b1e0, b1d0}, 0);
    chk("r0 byp0_EX zb1", {31'd0, b0e1}, 1);
    drive(0, 0, 0, 0, 1, 1, 0);
    step();
    drive(1, 0, 0, 0, 1, 0, 1);
    #1;
    chk("r0 load ldu zb0", {31'd0, ldu0}, 0);
    chk("r0 load ldu zb1", {31'd0, ldu1}, 1);
    step();

    // stall pair 01 also flags an error; then async reset mid-cycle clears all
    drive(1, 1, 0, 0, 1, 0, 2);
    sie = 0; sed = 1;
    step();
    chk("stall01 err", {31'd0, err0}, 1);
    sie = 0; sed = 0;
    chk("pre-reset cnt zb1", {28'd0, cnt1}, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async byp", {28'd0, b0e0, b0d0, b1e0, b1d0}, 0);
    chk("async byp zb1", {28'd0, b0e1, b0d1, b1e1, b1d1}, 0);
    chk("async ldu_stall", {30'd0, ldu0, ldu1}, 0);
    chk("async cnt", {12'd0, cnt1, cnt0}, 0);
    chk("async err", {30'd0, err0, err1}, 0);
    #2;
    rst_n = 1'b1;
    step();

    // 17 load-use pairs: one stall cycle each, narrow counter saturates at 0xF
    for (int k = 0; k < 17; k++) begin
      drive(0, 0, 0, 0, 1, 1, 2);
      #1;
      chk($sformatf("sat%0d load ldu", k), {31'd0, ldu0}, 0);
      step();
      drive(1, 2, 0, 0, 1, 0, 3);
      #1;
      chk($sformatf("sat%0d use ldu", k), {31'd0, ldu0}, 1);
      step();
      #1;
      chk($sformatf("sat%0d retry ldu", k), {31'd0, ldu0}, 0);
      step();
      chk($sformatf("sat%0d byp0_DM", k), {31'd0, b0d0}, 1);
    end
    chk("cnt16 after 17", {16'd0, cnt0}, 17);
    chk("cnt4 saturated", {28'd0, cnt1}, 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
